// File: rtl/instruction_loader.sv
// instruction_loader: parses a 16-bit word count plus big-endian 32-bit words into instruction memory writes.
// Define INSTRUCTION_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before completion.
module instruction_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_FLUSH, S_DONE, S_ERROR, S_CHECK
  } state_t;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  state_t      state_reg;
  logic [15:0] count_reg;
  logic [15:0] index_reg;
  logic [1:0]  byte_cnt_reg;
  logic [23:0] word_reg;
  logic        we_pending_reg;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]  csum_reg;
`endif

  logic        accept;
  logic [15:0] len_value;
  logic        len_too_big;
  logic        last_word;

  assign accept      = byte_valid && byte_ready;
  assign len_value   = {count_reg[15:8], byte_in};
  assign len_too_big = 32'(len_value) > (32'd1 << ADDR_WIDTH);
  assign last_word   = (index_reg == count_reg - 16'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      byte_ready     <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= BASE_ADDR;
      mem_wdata      <= 32'h0;
      cpu_hold       <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      count_reg      <= 16'h0;
      index_reg      <= 16'h0;
      byte_cnt_reg   <= 2'd0;
      word_reg       <= 24'h0;
      we_pending_reg <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      csum_reg       <= 8'h0;
`endif
    end else begin
      // The write strobe trails the registered word/address by one cycle.
      mem_we         <= we_pending_reg;
      we_pending_reg <= 1'b0;

      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_reg    <= S_LEN_HI;
            byte_ready   <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            index_reg    <= 16'h0;
            byte_cnt_reg <= 2'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_reg     <= 8'h0;
`endif
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            count_reg[15:8] <= byte_in;
            state_reg       <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            count_reg[7:0] <= byte_in;
            if (len_value == 16'h0) begin
              state_reg  <= CHECKSUM_EN ? S_CHECK : S_DONE;
              byte_ready <= CHECKSUM_EN;
              done       <= !CHECKSUM_EN;
              cpu_hold   <= CHECKSUM_EN;
            end else if (len_too_big) begin
              state_reg  <= S_ERROR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else begin
              state_reg  <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            word_reg     <= {word_reg[15:0], byte_in};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_reg     <= csum_reg ^ byte_in;
`endif
            if (byte_cnt_reg == 2'd3) begin
              mem_wdata      <= {word_reg, byte_in};
              mem_addr       <= BASE_ADDR + 32'({index_reg, 2'b00});
              we_pending_reg <= 1'b1;
              index_reg      <= index_reg + 16'd1;
              if (last_word) begin
                state_reg  <= S_FLUSH;
                byte_ready <= 1'b0;
              end
            end
          end
        end

        // Wait until the final strobe has actually been presented.
        S_FLUSH: begin
          if (mem_we) begin
            state_reg  <= CHECKSUM_EN ? S_CHECK : S_DONE;
            byte_ready <= CHECKSUM_EN;
            done       <= !CHECKSUM_EN;
            cpu_hold   <= CHECKSUM_EN;
          end
        end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_in == csum_reg) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state_reg <= S_ERROR;
              error     <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_reg  <= S_IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: vector table of load sessions plus hand-written timing/reset sequences.
// Honors INSTRUCTION_LOADER_CHECKSUM_EN by appending the expected checksum byte to valid streams.
module tb_instruction_loader;
  localparam int unsigned AW   = 2;
  localparam logic [31:0] BASE = 32'h0000_0040;

  logic        clock = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  typedef struct packed {
    logic [15:0]      count;
    int               nwords;
    logic [3:0][31:0] words;
    bit               toggle;
    bit               exp_err;
  } vec_t;

  instruction_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      $display("write addr=%h data=%h", mem_addr, mem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] c, input int n, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input bit tg, input bit er);
    vec_t v;
    v.count = c; v.nwords = n; v.words = {w3, w2, w1, w0};
    v.toggle = tg; v.exp_err = er;
    return v;
  endfunction

  function automatic logic [7:0] xsum(input int n, input logic [3:0][31:0] w);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++)
      x = x ^ w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    @(negedge clock);
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clock);
    end
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!byte_ready) begin
      checks++; errors++;
      $display("FAIL byte_ready timeout: byte %h never accepted, byte_ready=%b required 1", b, byte_ready);
    end
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_stream(input logic [15:0] cnt, input int n, input logic [3:0][31:0] w,
                             input bit gap, input bit with_csum);
    send_byte(cnt[15:8], gap);
    send_byte(cnt[7:0], gap);
    for (int i = 0; i < n; i++)
      for (int k = 3; k >= 0; k--)
        send_byte(w[i][8*k +: 8], gap);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    if (with_csum) send_byte(xsum(n, w), gap);
`endif
  endtask

  task automatic wait_end(input string name);
    int t = 0;
    while (!(done || error) && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!(done || error)) begin
      checks++; errors++;
      $display("FAIL %s: session timeout, done=%b error=%b required one of them 1", name, done, error);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = mk(16'd2,      2, 32'h3C080005, 32'h21090001, 32'h0, 32'h0, 1'b0, 1'b0);
    vecs[1] = mk(16'd2,      2, 32'h3C080005, 32'h21090001, 32'h0, 32'h0, 1'b1, 1'b0);
    vecs[2] = mk(16'd0,      0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vecs[3] = mk(16'd4,      4, 32'h11223344, 32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    vecs[4] = mk(16'd5,      0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    vecs[5] = mk(16'd1,      1, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vecs[6] = mk(16'h0100,   0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset byte_ready", 32'(byte_ready), 32'd0);
    check("reset mem_we",     32'(mem_we),     32'd0);
    check("reset mem_addr",   mem_addr,        BASE);
    check("reset mem_wdata",  mem_wdata,       32'h0);
    check("reset cpu_hold",   32'(cpu_hold),   32'd0);
    check("reset done",       32'(done),       32'd0);
    check("reset error",      32'(error),      32'd0);

    // start and byte_valid together in IDLE: that byte must be ignored.
    begin
      logic [3:0][31:0] w;
      w = {32'h0, 32'h0, 32'h0, 32'h12345678};
      wr_addr_q.delete(); wr_data_q.delete();
      @(negedge clock);
      start = 1'b1; byte_valid = 1'b1; byte_in = 8'h00;
      @(negedge clock);
      start = 1'b0; byte_valid = 1'b0;
      check("start cpu_hold", 32'(cpu_hold), 32'd1);
      send_stream(16'd1, 1, w, 1'b0, 1'b1);
      wait_end("start+valid");
      repeat (2) @(negedge clock);
      check("start+valid done",   32'(done), 32'd1);
      check("start+valid writes", 32'(wr_addr_q.size()), 32'd1);
      if (wr_data_q.size() > 0) check("start+valid data", wr_data_q[0], 32'h12345678);
    end

`ifndef INSTRUCTION_LOADER_CHECKSUM_EN
    // Final-word latency: strobe one cycle after the edge, done one edge later still.
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0);
    @(negedge clock);
    check("lat N mem_we",     32'(mem_we),   32'd0);
    check("lat N cpu_hold",   32'(cpu_hold), 32'd1);
    @(negedge clock);
    check("lat N+1 mem_we",   32'(mem_we),   32'd1);
    check("lat N+1 addr",     mem_addr,      BASE);
    check("lat N+1 data",     mem_wdata,     32'hDEADBEEF);
    check("lat N+1 done",     32'(done),     32'd0);
    @(negedge clock);
    check("lat N+2 done",     32'(done),     32'd1);
    check("lat N+2 cpu_hold", 32'(cpu_hold), 32'd0);
    check("lat N+2 mem_we",   32'(mem_we),   32'd0);
`endif

    // Reset right after the 4th byte of word 0: the pending write must be dropped.
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    wr_addr_q.delete(); wr_data_q.delete();
    reset = 1'b1;
    @(negedge clock);
    check("midreset mem_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("midreset writes",     32'(wr_addr_q.size()), 32'd0);
    check("midreset byte_ready", 32'(byte_ready), 32'd0);
    check("midreset mem_addr",   mem_addr,        BASE);
    check("midreset mem_wdata",  mem_wdata,       32'h0);
    check("midreset cpu_hold",   32'(cpu_hold),   32'd0);
    check("midreset done",       32'(done),       32'd0);
    check("midreset error",      32'(error),      32'd0);

    for (int v = 0; v < 7; v++) begin
      wr_addr_q.delete(); wr_data_q.delete();
      pulse_start();
      send_stream(vecs[v].count, vecs[v].nwords, vecs[v].words, vecs[v].toggle, !vecs[v].exp_err);
      wait_end($sformatf("v%0d", v));
      repeat (3) @(negedge clock);
      check($sformatf("v%0d done", v),       32'(done),       32'(!vecs[v].exp_err));
      check($sformatf("v%0d error", v),      32'(error),      32'(vecs[v].exp_err));
      check($sformatf("v%0d cpu_hold", v),   32'(cpu_hold),   32'(vecs[v].exp_err));
      check($sformatf("v%0d byte_ready", v), 32'(byte_ready), 32'd0);
      check($sformatf("v%0d writes", v), 32'(wr_addr_q.size()),
            vecs[v].exp_err ? 32'd0 : 32'(vecs[v].nwords));
      for (int i = 0; i < vecs[v].nwords; i++) begin
        if (!vecs[v].exp_err && i < wr_addr_q.size()) begin
          check($sformatf("v%0d addr%0d", v, i), wr_addr_q[i], BASE + 32'(4 * i));
          check($sformatf("v%0d data%0d", v, i), wr_data_q[i], vecs[v].words[i]);
        end
      end
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    // Wrong checksum: word stays written, session errors out.
    begin
      logic [3:0][31:0] w;
      w = {32'h0, 32'h0, 32'h0, 32'hAABBCCDD};
      wr_addr_q.delete(); wr_data_q.delete();
      pulse_start();
      send_stream(16'd1, 1, w, 1'b0, 1'b0);
      send_byte(8'hFF, 1'b0);
      wait_end("badsum");
      repeat (2) @(negedge clock);
      check("badsum error",  32'(error), 32'd1);
      check("badsum done",   32'(done),  32'd0);
      check("badsum writes", 32'(wr_addr_q.size()), 32'd1);
      if (wr_addr_q.size() > 0) check("badsum addr", wr_addr_q[0], BASE);
      pulse_start();
      send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
      wait_end("zero badsum");
      repeat (2) @(negedge clock);
      check("zero badsum error", 32'(error), 32'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
